// File: rtl/spad_load_dispatch_pkg.sv
// Shared types and default widths for the scratchpad load dispatcher.
// Instruction word layout is {op, mat, row, addr}, MSB first.
package spad_load_dispatch_pkg;

  localparam int WORD_W       = 16;
  localparam int BITS_PER_ROW = 128;
  localparam int ROW_S_W      = 4;
  localparam int MAT_S_W      = 4;

  typedef enum logic [1:0] {
    NOP         = 2'b00,
    LOAD_ROW    = 2'b01,
    LOAD_BURST  = 2'b10,
    LOAD_WEIGHT = 2'b11
  } load_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PUSH = 2'd2
  } ldisp_state_t;

  typedef struct packed {
    load_op_t             op;
    logic [MAT_S_W-1:0]   mat;
    logic [ROW_S_W-1:0]   row;
    logic [WORD_W-1:0]    addr;
  } ldisp_instr_t;

endpackage

// File: rtl/spad_load_dispatch_ch_onehot_dec.sv
// One-hot write-enable decoder: drives exactly one channel bit when en is
// high, all zeros otherwise.
module ch_onehot_dec #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [CH_W-1:0]   sel,
  input  logic              en,
  output logic [NUM_CH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/spad_load_dispatch.sv
// Pops load instructions, fetches rows from the scratchpad and pushes them
// into the weight FIFO selected by the low matrix-id bits.
module spad_load_dispatch
  import spad_load_dispatch_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = WORD_W,
  parameter int DATA_W     = BITS_PER_ROW,
  parameter int ROW_W      = ROW_S_W,
  parameter int MAT_W      = MAT_S_W,
  parameter int ROW_STRIDE = DATA_W / 8
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          instr_empty,
  input  logic [2+MAT_W+ROW_W+ADDR_W-1:0] instr_rdata,
  output logic                          instr_ren,
  output logic                          sload,
  output logic [ADDR_W-1:0]             load_addr,
  input  logic                          sload_hit,
  input  logic [DATA_W-1:0]             load_data,
  input  logic [NUM_CH-1:0]             wfifo_full,
  output logic [NUM_CH-1:0]             wfifo_wen,
  output logic [DATA_W+MAT_W+ROW_W-1:0] wfifo_wdata,
  output logic                          new_weight,
  output logic                          busy,
  output logic [15:0]                   rows_done,
  output ldisp_state_t                  dbgState
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int IW   = 2 + MAT_W + ROW_W + ADDR_W;

  ldisp_state_t state, nextState;

  load_op_t          opReg;
  logic [MAT_W-1:0]  matReg;
  logic [ROW_W-1:0]  rowReg;
  logic [ADDR_W-1:0] curAddr;
  logic [ROW_W:0]    cnt;
  logic [DATA_W-1:0] dataReg;
  logic [15:0]       rowsDone;

  load_op_t          instrOp;
  logic [MAT_W-1:0]  instrMat;
  logic [ROW_W-1:0]  instrRow;
  logic [ADDR_W-1:0] instrAddr;
  logic [CH_W-1:0]   ch;
  logic [ROW_W-1:0]  rowField;
  logic              take;
  logic              pushNow;
  logic              lastRow;

  assign instrOp   = load_op_t'(instr_rdata[IW-1 -: 2]);
  assign instrMat  = instr_rdata[ADDR_W+ROW_W +: MAT_W];
  assign instrRow  = instr_rdata[ADDR_W +: ROW_W];
  assign instrAddr = instr_rdata[ADDR_W-1:0];

  assign ch       = matReg[CH_W-1:0];
  assign take     = (state == ST_IDLE) && !instr_empty;
  assign pushNow  = (state == ST_PUSH) && !wfifo_full[ch];
  // cnt carries one extra bit so a full-range burst ends on cnt == row, not on wrap
  assign lastRow  = (opReg == LOAD_ROW) || (cnt == {1'b0, rowReg});
  assign rowField = (opReg == LOAD_ROW) ? rowReg : cnt[ROW_W-1:0];

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (take && instrOp != NOP) nextState = ST_REQ;
      ST_REQ:  if (sload_hit) nextState = ST_PUSH;
      ST_PUSH: if (pushNow) nextState = lastRow ? ST_IDLE : ST_REQ;
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      opReg    <= NOP;
      matReg   <= '0;
      rowReg   <= '0;
      curAddr  <= '0;
      cnt      <= '0;
      dataReg  <= '0;
      rowsDone <= '0;
    end else begin
      if (take) begin
        opReg   <= instrOp;
        matReg  <= instrMat;
        rowReg  <= instrRow;
        curAddr <= instrAddr;
        cnt     <= '0;
      end
      if (state == ST_REQ && sload_hit) dataReg <= load_data;
      if (pushNow) begin
        // Running address replaces addr + cnt*ROW_STRIDE; wraps at ADDR_W
        if (!lastRow) begin
          cnt     <= cnt + 1'b1;
          curAddr <= curAddr + ADDR_W'(ROW_STRIDE);
        end
        if (rowsDone != 16'hFFFF) rowsDone <= rowsDone + 16'd1;
      end
    end
  end

  ch_onehot_dec #(.NUM_CH(NUM_CH)) uDec (
    .sel    (ch),
    .en     (pushNow),
    .onehot (wfifo_wen)
  );

  assign instr_ren   = take && nRST;
  assign sload       = (state == ST_REQ);
  assign load_addr   = curAddr;
  assign wfifo_wdata = {matReg, rowField, dataReg};
  assign new_weight  = pushNow && (opReg == LOAD_WEIGHT) && lastRow;
  assign busy        = (state != ST_IDLE);
  assign rows_done   = rowsDone;
  assign dbgState    = state;

endmodule
